conv_layer_sequencer: RTL and testbench
=======================================

# conv_layer_sequencer

Parametrised sequencer for the convolution layer. It issues preload, shift and load commands to the input interface and counts weight, shift and row-pass cycles against the interface acknowledgements. It flags each completed output pixel with its row/column coordinates for the output interface, and signals frame completion. It sits between the layer top level and the input/output interfaces. It adds start/done framing, enable stalling without losing acks, a soft clear and protocol-error detection.

## Interface
- WEIGHT_CYCLES, 3, shift acks per output pixel (≥1)
- SHIFT_CYCLES, 4, output pixels per row pass (≥1)
- ROW_PASSES, 2, row passes (preloads) per frame (≥1)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse, honoured only in IDLE
- enable  in  1  1 = advance; 0 = freeze state, counters and outputs' next values
- clear  in  1  synchronous abort to IDLE, clears counters, pending ack and error
- input_interface_ack  in  2  0 NONE, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN; single-cycle pulses
- input_interface_cmd  out  2  0 IDLE, 1 PRELOAD_START, 2 SHIFT_START, 3 LOAD_START; single-cycle pulses
- current_state  out  3  0 IDLE, 1 PRELOAD, 2 SHIFT, 3 LOAD, 4 DONE
- result_valid  out  1  one-cycle pulse per completed output pixel
- out_row  out  $clog2(ROW_PASSES) min 1  row of pixel flagged by result_valid
- out_col  out  $clog2(SHIFT_CYCLES) min 1  column of pixel flagged by result_valid
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at frame end
- protocol_err  out  1  sticky; set by an ack not matching the current state

## Operation
- Reset: state IDLE. cmd 0, result_valid 0, done 0, protocol_err 0, out_row/out_col 0. All counters 0, pending ack cleared.
- Effective ack: the incoming ack, or the pending ack if one is held. A non-NONE ack arriving while enable=0 is stored in a 1-deep pending register and consumed in the first cycle with enable=1. A second ack arriving while one is pending sets protocol_err and overwrites the pending ack.
- IDLE: start=1 → PRELOAD, cmd=PRELOAD_START. Counters are zeroed.
- PRELOAD: PRELOAD_FIN → SHIFT, cmd=SHIFT_START.
- SHIFT: on SHIFT_FIN, act on the counters as follows.
  - If weight_cnt<WEIGHT_CYCLES-1: increment weight_cnt, cmd=SHIFT_START, stay in SHIFT.
  - Otherwise: weight_cnt←0, result_valid=1 with out_row=row_cnt and out_col=shift_cnt, then the following cases apply.
    - If shift_cnt<SHIFT_CYCLES-1: increment shift_cnt, → LOAD, cmd=LOAD_START.
    - Else if row_cnt<ROW_PASSES-1: shift_cnt←0, increment row_cnt, → PRELOAD, cmd=PRELOAD_START.
    - Else: → DONE, cmd=IDLE.
- LOAD: LOAD_FIN → SHIFT, cmd=SHIFT_START.
- DONE: done=1 for one cycle, → IDLE with counters zeroed. busy is still 1 during DONE.
- Mismatched non-NONE ack (e.g. LOAD_FIN in SHIFT, any ack in IDLE/DONE): set protocol_err. The ack is ignored and state is unchanged.
- Counter widths are $clog2(param) with a minimum of 1. Counters never exceed param-1, and wrap only as described above.

## Timing
- All outputs are registered and update on the same edge as the state transition. The cmd for the new state is visible the cycle the state is visible, i.e. 1 cycle after the triggering start/ack.
- cmd, result_valid and done are high for exactly one cycle and 0 otherwise.
- enable=0: no transitions, and the pulsed outputs are 0. On re-enable, a pending ack is processed in the first enabled cycle, with a 1-cycle latency from that edge.
- clear has priority over start, enable and ack. It takes effect next edge and drives all outputs to their reset values.
- start while busy: ignored, no error.
- Frame length in acks: ROW_PASSES preloads, ROW_PASSES·(SHIFT_CYCLES-1) loads, WEIGHT_CYCLES·SHIFT_CYCLES·ROW_PASSES shifts.

## Test plan
- Defaults, ideal responder (each ack 2 cycles after its cmd) → 2 PRELOAD_START, 6 LOAD_START, 24 SHIFT_FIN consumed. Expect 8 result_valid with (row,col) = (0,0)…(0,3),(1,0)…(1,3), one done, protocol_err=0.
- Drop enable across a SHIFT_FIN cycle, hold it low 5 cycles → ack retained. The next cmd appears 1 cycle after enable returns, and totals match the first scenario.
- Inject LOAD_FIN while in PRELOAD → protocol_err=1 and stays 1. State remains PRELOAD, and the frame then completes normally.
- Assert clear mid-frame in LOAD with start high on the same cycle → next cycle IDLE, busy=0, protocol_err=0. A later start runs a full frame from (0,0).
- Assert rst_n low mid-SHIFT asynchronously → outputs go to reset values immediately, with no spurious cmd after release.
- WEIGHT_CYCLES=1, SHIFT_CYCLES=1, ROW_PASSES=1 → start, PRELOAD_FIN, SHIFT_FIN produce result_valid (0,0) then done. No LOAD_START is ever issued.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//
// Purpose: sequences one convolution frame. Each row pass is one PRELOAD
// followed by SHIFT_CYCLES output pixels, with a LOAD between consecutive
// pixels. Each pixel needs WEIGHT_CYCLES shift acknowledgements from the
// input interface. The block flags every completed pixel with its row and
// column for the output interface, and reports frame completion.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 frame start pulse, honoured only in IDLE
//   enable                1 = advance, 0 = freeze (acks are held, not lost)
//   clear                 synchronous abort to IDLE, highest priority
//   input_interface_ack   0 NONE, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN
//   input_interface_cmd   0 IDLE, 1 PRELOAD_START, 2 SHIFT_START, 3 LOAD_START
//   current_state         0 IDLE, 1 PRELOAD, 2 SHIFT, 3 LOAD, 4 DONE
//   result_valid          one-cycle pulse per completed output pixel
//   out_row, out_col      coordinates of the pixel flagged by result_valid
//   busy                  high in any state other than IDLE
//   done                  one-cycle pulse at frame end (coincides with DONE)
//   protocol_err          sticky flag for an ack that does not fit the state
module conv_layer_sequencer #(
  parameter int WEIGHT_CYCLES = 3,
  parameter int SHIFT_CYCLES  = 4,
  parameter int ROW_PASSES    = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 start,
  input  logic                                                 enable,
  input  logic                                                 clear,
  input  logic [1:0]                                           input_interface_ack,
  output logic [1:0]                                           input_interface_cmd,
  output logic [2:0]                                           current_state,
  output logic                                                 result_valid,
  output logic [((ROW_PASSES > 1) ? $clog2(ROW_PASSES) : 1)-1:0]     out_row,
  output logic [((SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1)-1:0] out_col,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 protocol_err
);

  localparam int WGT_W = (WEIGHT_CYCLES > 1) ? $clog2(WEIGHT_CYCLES) : 1;
  localparam int COL_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam int ROW_W = (ROW_PASSES > 1) ? $clog2(ROW_PASSES) : 1;

  localparam logic [WGT_W-1:0] WGT_LAST = WGT_W'(WEIGHT_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SHIFT_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_PASSES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRELOAD = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Ack and command encodings share values: each FIN answers the START
  // that has the same code.
  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_PRELOAD = 2'd1;
  localparam logic [1:0] CODE_SHIFT   = 2'd2;
  localparam logic [1:0] CODE_LOAD    = 2'd3;

  logic [2:0]       state_q,      state_d;
  logic [1:0]       cmd_q,        cmd_d;
  logic             valid_q,      valid_d;
  logic             done_q,       done_d;
  logic             err_q,        err_d;
  logic [ROW_W-1:0] out_row_q,    out_row_d;
  logic [COL_W-1:0] out_col_q,    out_col_d;
  logic [WGT_W-1:0] weight_cnt_q, weight_cnt_d;
  logic [COL_W-1:0] shift_cnt_q,  shift_cnt_d;
  logic [ROW_W-1:0] row_cnt_q,    row_cnt_d;
  logic             pend_vld_q,   pend_vld_d;
  logic [1:0]       pend_ack_q,   pend_ack_d;
  logic [1:0]       eff_ack;

  // An ack that arrived during a stall takes precedence over the live input.
  assign eff_ack = pend_vld_q ? pend_ack_q : input_interface_ack;

  // Next-state logic. cmd, result_valid and done default to 0 so they only
  // ever pulse for the single cycle after the event that produced them.
  always_comb begin
    state_d      = state_q;
    cmd_d        = CODE_NONE;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    weight_cnt_d = weight_cnt_q;
    shift_cnt_d  = shift_cnt_q;
    row_cnt_d    = row_cnt_q;
    pend_vld_d   = pend_vld_q;
    pend_ack_d   = pend_ack_q;

    if (clear) begin
      state_d      = S_IDLE;
      err_d        = 1'b0;
      out_row_d    = '0;
      out_col_d    = '0;
      weight_cnt_d = '0;
      shift_cnt_d  = '0;
      row_cnt_d    = '0;
      pend_vld_d   = 1'b0;
      pend_ack_d   = CODE_NONE;
    end else if (!enable) begin
      // Stalled: hold the ack for later; a second one while the first is
      // still held is a protocol violation and replaces it.
      if (input_interface_ack != CODE_NONE) begin
        if (pend_vld_q) begin
          err_d = 1'b1;
        end
        pend_vld_d = 1'b1;
        pend_ack_d = input_interface_ack;
      end
    end else begin
      // The held ack is consumed now; a live ack in this same cycle would
      // otherwise be lost, so it becomes the next held ack.
      if (pend_vld_q) begin
        pend_vld_d = (input_interface_ack != CODE_NONE);
        pend_ack_d = input_interface_ack;
      end

      case (state_q)
        S_IDLE: begin
          if (eff_ack != CODE_NONE) begin
            err_d = 1'b1;
          end
          if (start) begin
            state_d      = S_PRELOAD;
            cmd_d        = CODE_PRELOAD;
            weight_cnt_d = '0;
            shift_cnt_d  = '0;
            row_cnt_d    = '0;
          end
        end

        S_PRELOAD: begin
          if (eff_ack == CODE_PRELOAD) begin
            state_d = S_SHIFT;
            cmd_d   = CODE_SHIFT;
          end else if (eff_ack != CODE_NONE) begin
            err_d = 1'b1;
          end
        end

        S_SHIFT: begin
          if (eff_ack == CODE_SHIFT) begin
            if (weight_cnt_q < WGT_LAST) begin
              weight_cnt_d = weight_cnt_q + 1'b1;
              cmd_d        = CODE_SHIFT;
            end else begin
              weight_cnt_d = '0;
              valid_d      = 1'b1;
              out_row_d    = row_cnt_q;
              out_col_d    = shift_cnt_q;
              if (shift_cnt_q < COL_LAST) begin
                shift_cnt_d = shift_cnt_q + 1'b1;
                state_d     = S_LOAD;
                cmd_d       = CODE_LOAD;
              end else if (row_cnt_q < ROW_LAST) begin
                shift_cnt_d = '0;
                row_cnt_d   = row_cnt_q + 1'b1;
                state_d     = S_PRELOAD;
                cmd_d       = CODE_PRELOAD;
              end else begin
                // done is raised on entry so it is visible together with DONE
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
          end else if (eff_ack != CODE_NONE) begin
            err_d = 1'b1;
          end
        end

        S_LOAD: begin
          if (eff_ack == CODE_LOAD) begin
            state_d = S_SHIFT;
            cmd_d   = CODE_SHIFT;
          end else if (eff_ack != CODE_NONE) begin
            err_d = 1'b1;
          end
        end

        S_DONE: begin
          if (eff_ack != CODE_NONE) begin
            err_d = 1'b1;
          end
          state_d      = S_IDLE;
          weight_cnt_d = '0;
          shift_cnt_d  = '0;
          row_cnt_d    = '0;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= CODE_NONE;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      weight_cnt_q <= '0;
      shift_cnt_q  <= '0;
      row_cnt_q    <= '0;
      pend_vld_q   <= 1'b0;
      pend_ack_q   <= CODE_NONE;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      weight_cnt_q <= weight_cnt_d;
      shift_cnt_q  <= shift_cnt_d;
      row_cnt_q    <= row_cnt_d;
      pend_vld_q   <= pend_vld_d;
      pend_ack_q   <= pend_ack_d;
    end
  end

  assign input_interface_cmd = cmd_q;
  assign current_state       = state_q;
  assign result_valid        = valid_q;
  assign out_row             = out_row_q;
  assign out_col             = out_col_q;
  assign done                = done_q;
  assign protocol_err        = err_q;
  // Pure decode of the state register, so it tracks state with no extra lag.
  assign busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer
//
// Directed bench for conv_layer_sequencer. One instance uses the default
// parameters (3/4/2); a second uses the minimal 1/1/1 configuration.
// Expected values are hand-derived from the frame structure: 2 preloads,
// 6 loads, 24 shifts, and 8 pixels in row-major order per default frame.
module tb_conv_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, enable, clear;
  logic [1:0] ack;
  logic [1:0] cmd;
  logic [2:0] state;
  logic       rv;
  logic [0:0] outRow;
  logic [1:0] outCol;
  logic       busy, done, err;

  logic       mStart, mEnable, mClear;
  logic [1:0] mAck;
  logic [1:0] mCmd;
  logic [2:0] mState;
  logic       mRv;
  logic [0:0] mRow;
  logic [0:0] mCol;
  logic       mBusy, mDone, mErr;

  int testCount = 0;
  int failCount = 0;

  conv_layer_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .enable              (enable),
    .clear               (clear),
    .input_interface_ack (ack),
    .input_interface_cmd (cmd),
    .current_state       (state),
    .result_valid        (rv),
    .out_row             (outRow),
    .out_col             (outCol),
    .busy                (busy),
    .done                (done),
    .protocol_err        (err)
  );

  conv_layer_sequencer #(
    .WEIGHT_CYCLES (1),
    .SHIFT_CYCLES  (1),
    .ROW_PASSES    (1)
  ) dutMin (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (mStart),
    .enable              (mEnable),
    .clear               (mClear),
    .input_interface_ack (mAck),
    .input_interface_cmd (mCmd),
    .current_state       (mState),
    .result_valid        (mRv),
    .out_row             (mRow),
    .out_col             (mCol),
    .busy                (mBusy),
    .done                (mDone),
    .protocol_err        (mErr)
  );

  always #5 clk = ~clk;

  // Watchdog in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Event monitor sampling on the falling edge, away from the active edge.
  logic monReset = 1'b0;
  int   nPre, nLoad, nShiftCmd, nRv, nDone, mNLoad;
  int   rvRow [16];
  int   rvCol [16];

  always @(negedge clk) begin
    if (monReset) begin
      nPre = 0; nLoad = 0; nShiftCmd = 0; nRv = 0; nDone = 0; mNLoad = 0;
    end else begin
      if (cmd == 2'd1) nPre++;
      if (cmd == 2'd2) nShiftCmd++;
      if (cmd == 2'd3) nLoad++;
      if (rv === 1'b1) begin
        if (nRv < 16) begin
          rvRow[nRv] = int'(outRow);
          rvCol[nRv] = int'(outCol);
        end
        nRv++;
      end
      if (done === 1'b1) nDone++;
      if (mCmd == 2'd3) mNLoad++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle ack pulse to the default instance.
  task automatic applyStimulus(input logic [1:0] a);
    ack = a;
    tick;
    ack = 2'd0;
  endtask

  task automatic clearMon;
    monReset = 1'b1;
    tick;
    monReset = 1'b0;
  endtask

  // Ideal responder: answer each command two cycles after it appears,
  // optionally stalling enable across the stallAt-th SHIFT_FIN.
  task automatic driveFrame(input int stallAt, output int shiftFins, output bit finished);
    logic [1:0] c;
    int guard;
    shiftFins = 0;
    finished = 1'b0;
    guard = 0;
    while (!finished && guard < 600) begin
      if (done === 1'b1) begin
        finished = 1'b1;
      end else if (cmd !== 2'd0) begin
        c = cmd;
        tick;
        tick;
        ack = c;
        if (c == 2'd2) begin
          shiftFins++;
          if (shiftFins == stallAt) enable = 1'b0;
        end
        tick;
        ack = 2'd0;
        guard += 3;
        if (c == 2'd2 && shiftFins == stallAt) begin
          repeat (4) tick;
          checkOutput("stall_state", 32'(state), 32'd2);
          checkOutput("stall_cmd", 32'(cmd), 32'd0);
          enable = 1'b1;
          tick;
          checkOutput("resume_cmd", 32'(cmd), 32'd2);
          guard += 5;
        end
      end else begin
        tick;
        guard++;
      end
    end
    checkOutput("frame_done_seen", 32'(finished), 32'd1);
  endtask

  task automatic checkFrame(input string tag, input int shiftFins);
    checkOutput({tag, "_preloads"}, 32'(nPre), 32'd2);
    checkOutput({tag, "_loads"}, 32'(nLoad), 32'd6);
    checkOutput({tag, "_shift_cmds"}, 32'(nShiftCmd), 32'd24);
    checkOutput({tag, "_shift_fins"}, 32'(shiftFins), 32'd24);
    checkOutput({tag, "_results"}, 32'(nRv), 32'd8);
    checkOutput({tag, "_dones"}, 32'(nDone), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_row%0d", tag, i), 32'(rvRow[i]), 32'(i / 4));
      checkOutput($sformatf("%s_col%0d", tag, i), 32'(rvCol[i]), 32'(i % 4));
    end
  endtask

  initial begin
    int  fins;
    bit  fin;

    rst_n = 1'b0;
    start = 1'b0; enable = 1'b1; clear = 1'b0; ack = 2'd0;
    mStart = 1'b0; mEnable = 1'b1; mClear = 1'b0; mAck = 2'd0;
    for (int i = 0; i < 16; i++) begin
      rvRow[i] = -1;
      rvCol[i] = -1;
    end
    monReset = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    monReset = 1'b0;
    tick;

    // Reset state
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_cmd", 32'(cmd), 32'd0);
    checkOutput("rst_valid", 32'(rv), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_row", 32'(outRow), 32'd0);
    checkOutput("rst_col", 32'(outCol), 32'd0);

    // Scenario 1: full frame, ideal responder
    $display("[TB] scenario 1: nominal frame");
    clearMon;
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("s1_start_cmd", 32'(cmd), 32'd1);
    checkOutput("s1_start_busy", 32'(busy), 32'd1);
    driveFrame(0, fins, fin);
    checkOutput("s1_done_state", 32'(state), 32'd4);
    checkOutput("s1_done_busy", 32'(busy), 32'd1);
    tick;
    checkOutput("s1_idle_state", 32'(state), 32'd0);
    checkOutput("s1_idle_done", 32'(done), 32'd0);
    checkFrame("s1", fins);
    checkOutput("s1_err", 32'(err), 32'd0);

    // Scenario 2: enable dropped across the first SHIFT_FIN
    $display("[TB] scenario 2: enable stall");
    clearMon;
    start = 1'b1;
    tick;
    start = 1'b0;
    driveFrame(1, fins, fin);
    tick;
    checkFrame("s2", fins);
    checkOutput("s2_err", 32'(err), 32'd0);

    // Scenario 3: LOAD_FIN while in PRELOAD, start while busy
    $display("[TB] scenario 3: protocol error");
    clearMon;
    start = 1'b1;
    tick;
    start = 1'b0;
    applyStimulus(2'd3);
    checkOutput("s3_err_set", 32'(err), 32'd1);
    checkOutput("s3_state_kept", 32'(state), 32'd1);
    checkOutput("s3_no_cmd", 32'(cmd), 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("s3_busy_start_state", 32'(state), 32'd1);
    checkOutput("s3_busy_start_cmd", 32'(cmd), 32'd0);
    applyStimulus(2'd1);
    checkOutput("s3_shift_cmd", 32'(cmd), 32'd2);
    driveFrame(0, fins, fin);
    tick;
    checkFrame("s3", fins);
    checkOutput("s3_err_sticky", 32'(err), 32'd1);

    // Scenario 4: clear in LOAD with start high
    $display("[TB] scenario 4: clear mid-frame");
    start = 1'b1;
    tick;
    start = 1'b0;
    applyStimulus(2'd1);
    applyStimulus(2'd2);
    applyStimulus(2'd2);
    applyStimulus(2'd2);
    checkOutput("s4_in_load", 32'(state), 32'd3);
    checkOutput("s4_load_cmd", 32'(cmd), 32'd3);
    clear = 1'b1;
    start = 1'b1;
    tick;
    clear = 1'b0;
    start = 1'b0;
    checkOutput("s4_clr_state", 32'(state), 32'd0);
    checkOutput("s4_clr_busy", 32'(busy), 32'd0);
    checkOutput("s4_clr_err", 32'(err), 32'd0);
    checkOutput("s4_clr_cmd", 32'(cmd), 32'd0);
    checkOutput("s4_clr_valid", 32'(rv), 32'd0);
    clearMon;
    start = 1'b1;
    tick;
    start = 1'b0;
    driveFrame(0, fins, fin);
    tick;
    checkFrame("s4", fins);

    // Scenario 5: asynchronous reset in SHIFT
    $display("[TB] scenario 5: async reset");
    start = 1'b1;
    tick;
    start = 1'b0;
    applyStimulus(2'd1);
    checkOutput("s5_in_shift", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_state", 32'(state), 32'd0);
    checkOutput("s5_rst_cmd", 32'(cmd), 32'd0);
    checkOutput("s5_rst_busy", 32'(busy), 32'd0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput($sformatf("s5_quiet_cmd%0d", i), 32'(cmd), 32'd0);
      checkOutput($sformatf("s5_quiet_state%0d", i), 32'(state), 32'd0);
    end
    clearMon;
    start = 1'b1;
    tick;
    start = 1'b0;
    driveFrame(0, fins, fin);
    tick;
    checkFrame("s5", fins);

    // Scenario 6: minimal 1/1/1 configuration
    $display("[TB] scenario 6: minimal parameters");
    mStart = 1'b1;
    tick;
    mStart = 1'b0;
    checkOutput("s6_pre_cmd", 32'(mCmd), 32'd1);
    checkOutput("s6_pre_state", 32'(mState), 32'd1);
    mAck = 2'd1;
    tick;
    mAck = 2'd0;
    checkOutput("s6_shift_cmd", 32'(mCmd), 32'd2);
    checkOutput("s6_shift_state", 32'(mState), 32'd2);
    mAck = 2'd2;
    tick;
    mAck = 2'd0;
    checkOutput("s6_valid", 32'(mRv), 32'd1);
    checkOutput("s6_row", 32'(mRow), 32'd0);
    checkOutput("s6_col", 32'(mCol), 32'd0);
    checkOutput("s6_done", 32'(mDone), 32'd1);
    checkOutput("s6_done_state", 32'(mState), 32'd4);
    checkOutput("s6_done_cmd", 32'(mCmd), 32'd0);
    tick;
    checkOutput("s6_idle_state", 32'(mState), 32'd0);
    checkOutput("s6_idle_done", 32'(mDone), 32'd0);
    checkOutput("s6_idle_busy", 32'(mBusy), 32'd0);
    checkOutput("s6_err", 32'(mErr), 32'd0);
    checkOutput("s6_no_load", 32'(mNLoad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
